// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_arbiter
// Description : Round-robin arbiter sharing one MFA/MFC RAM port between the
//               instruction-fetch path and the load/store data path.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   output logic              ifDone,
   output logic              ifErr,
   input  logic              dReq,
   input  logic              dRW,
   input  logic [1:0]        dSize,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWdata,
   output logic              dDone,
   output logic              dErr,
   output logic [DATA_W-1:0] rdata,
   output logic              owner,
   output logic              busy,
   output logic              ramMFA,
   output logic              ramRW,
   output logic [ADDR_W-1:0] ramAddress,
   output logic [1:0]        ramDataSize,
   output logic [DATA_W-1:0] ramDataOut,
   input  logic [DATA_W-1:0] ramDataIn,
   input  logic              ramMFC
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   localparam logic [7:0] c_timeout = 8'(TIMEOUT);

   state_t            r_state;
   logic              r_owner;
   logic              r_mfa;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [7:0]        r_cnt;
   logic              r_ifdone;
   logic              r_iferr;
   logic              r_ddone;
   logic              r_derr;

   logic              w_any_req;
   logic              w_pick_data;
   logic [1:0]        w_size;
   logic [ADDR_W-1:0] w_addr;
   logic              w_bad;
   logic [7:0]        w_cnt_next;

   // On a conflict the requester that did not own the last access wins.
   assign w_any_req   = ifReq | dReq;
   assign w_pick_data = (ifReq & dReq) ? ~r_owner : dReq;
   assign w_size      = w_pick_data ? dSize : 2'b11;
   assign w_addr      = w_pick_data ? dAddr : ifAddr;
   assign w_bad       = (w_size == 2'b10) ||
                        ((w_size == 2'b11) && (w_addr[1:0] != 2'b00)) ||
                        ((w_size == 2'b01) && w_addr[0]);
   assign w_cnt_next  = r_cnt + 8'd1;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_owner  <= 1'b1;
         r_mfa    <= 1'b0;
         r_rw     <= 1'b0;
         r_addr   <= '0;
         r_size   <= 2'b00;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_cnt    <= 8'd0;
         r_ifdone <= 1'b0;
         r_iferr  <= 1'b0;
         r_ddone  <= 1'b0;
         r_derr   <= 1'b0;
      end else begin
         r_ifdone <= 1'b0;
         r_iferr  <= 1'b0;
         r_ddone  <= 1'b0;
         r_derr   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_pick_data;
                  r_addr  <= w_addr;
                  r_size  <= w_size;
                  r_rw    <= w_pick_data & dRW;
                  r_wdata <= w_pick_data ? dWdata : '0;
                  r_cnt   <= 8'd0;
                  if (w_bad) begin
                     r_state <= ERR;
                     r_derr  <= w_pick_data;
                     r_iferr <= ~w_pick_data;
                  end else begin
                     r_state <= ACCESS;
                     r_mfa   <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (ramMFC) begin
                  if (!r_rw) begin
                     r_rdata <= ramDataIn;
                  end
                  r_state  <= DONE;
                  r_mfa    <= 1'b0;
                  r_ddone  <= r_owner;
                  r_ifdone <= ~r_owner;
               end else begin
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == c_timeout) begin
                     r_state <= ERR;
                     r_mfa   <= 1'b0;
                     r_derr  <= r_owner;
                     r_iferr <= ~r_owner;
                  end
               end
            end
            DONE:    r_state <= IDLE;
            ERR:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ifDone      = r_ifdone;
   assign ifErr       = r_iferr;
   assign dDone       = r_ddone;
   assign dErr        = r_derr;
   assign rdata       = r_rdata;
   assign owner       = r_owner;
   assign busy        = (r_state != IDLE);
   assign ramMFA      = r_mfa;
   assign ramRW       = r_rw;
   assign ramAddress  = r_addr;
   assign ramDataSize = r_size;
   assign ramDataOut  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_arbiter
// Description : Directed self-checking bench for ram_access_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   logic              Clk = 1'b0;
   logic              reset;
   logic              ifReq;
   logic [ADDR_W-1:0] ifAddr;
   logic              ifDone;
   logic              ifErr;
   logic              dReq;
   logic              dRW;
   logic [1:0]        dSize;
   logic [ADDR_W-1:0] dAddr;
   logic [DATA_W-1:0] dWdata;
   logic              dDone;
   logic              dErr;
   logic [DATA_W-1:0] rdata;
   logic              owner;
   logic              busy;
   logic              ramMFA;
   logic              ramRW;
   logic [ADDR_W-1:0] ramAddress;
   logic [1:0]        ramDataSize;
   logic [DATA_W-1:0] ramDataOut;
   logic [DATA_W-1:0] ramDataIn;
   logic              ramMFC;

   int n_assert = 0;
   int n_fail   = 0;

   ram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
      .Clk(Clk), .reset(reset),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifDone(ifDone), .ifErr(ifErr),
      .dReq(dReq), .dRW(dRW), .dSize(dSize), .dAddr(dAddr), .dWdata(dWdata),
      .dDone(dDone), .dErr(dErr), .rdata(rdata), .owner(owner), .busy(busy),
      .ramMFA(ramMFA), .ramRW(ramRW), .ramAddress(ramAddress),
      .ramDataSize(ramDataSize), .ramDataOut(ramDataOut),
      .ramDataIn(ramDataIn), .ramMFC(ramMFC)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_pulses(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, ifDone, ifErr, dDone, dErr}, {28'd0, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int mfa_cnt;
      reset = 1'b1; ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dRW = 1'b0;
      dSize = 2'b00; dAddr = '0; dWdata = '0; ramDataIn = '0; ramMFC = 1'b0;
      repeat (2) tick();
      chk("reset_pulses", {28'd0, ifDone, ifErr, dDone, dErr}, 32'd0);
      chk("reset_mfa", ramMFA, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_owner", owner, 1'b1);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_addr", ramAddress, 32'd0);
      reset = 1'b0;
      tick();

      // Simultaneous requests right after reset: fetch first, then data.
      ifReq = 1'b1; ifAddr = 9'h100;
      dReq = 1'b1; dRW = 1'b1; dSize = 2'b11; dAddr = 9'h080; dWdata = 32'hCAFEF00D;
      tick();
      chk("both_grant_owner", owner, 1'b0);
      chk("both_grant_addr", ramAddress, 32'h100);
      chk("both_grant_mfa", ramMFA, 1'b1);
      ramMFC = 1'b1; ramDataIn = 32'h11112222;
      tick();
      chk_pulses("both_fetch_done", 4'b1000);
      chk("both_fetch_rdata", rdata, 32'h11112222);
      ifReq = 1'b0; ramMFC = 1'b0;
      tick();
      chk_pulses("both_fetch_done_end", 4'b0000);
      chk("both_idle_busy", busy, 1'b0);
      tick();
      chk("both_data_owner", owner, 1'b1);
      chk("both_data_mfa", ramMFA, 1'b1);
      chk("both_data_rw", ramRW, 1'b1);
      chk("both_data_addr", ramAddress, 32'h080);
      chk("both_data_wdata", ramDataOut, 32'hCAFEF00D);
      ramMFC = 1'b1;
      tick();
      chk_pulses("both_data_done", 4'b0010);
      chk("both_write_keeps_rdata", rdata, 32'h11112222);
      dReq = 1'b0; ramMFC = 1'b0;
      tick();

      // Fetch from 0x040, MFC on the 2nd ACCESS cycle.
      ifReq = 1'b1; ifAddr = 9'h040;
      tick();
      chk("fetch_mfa1", ramMFA, 1'b1);
      chk("fetch_size", ramDataSize, 2'b11);
      chk("fetch_rw", ramRW, 1'b0);
      chk("fetch_wdata", ramDataOut, 32'd0);
      tick();
      chk("fetch_mfa2", ramMFA, 1'b1);
      chk_pulses("fetch_no_early_done", 4'b0000);
      ramMFC = 1'b1; ramDataIn = 32'h20210005;
      tick();
      chk_pulses("fetch_done", 4'b1000);
      chk("fetch_mfa_off", ramMFA, 1'b0);
      chk("fetch_rdata", rdata, 32'h20210005);
      chk("fetch_owner", owner, 1'b0);
      ifReq = 1'b0;
      tick();
      chk_pulses("fetch_done_one_cycle", 4'b0000);
      chk("fetch_idle", busy, 1'b0);

      // Misaligned halfword store; MFC held high must be ignored outside ACCESS.
      dReq = 1'b1; dRW = 1'b1; dSize = 2'b01; dAddr = 9'h013; dWdata = 32'hAAAA5555;
      tick();
      chk_pulses("mis_half_err", 4'b0001);
      chk("mis_half_mfa", ramMFA, 1'b0);
      chk("mis_half_busy", busy, 1'b1);
      dReq = 1'b0;
      tick();
      chk_pulses("mis_half_err_end", 4'b0000);
      chk("mis_half_rdata", rdata, 32'h20210005);
      ramMFC = 1'b0;

      // Reserved size is rejected even at an aligned address.
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b10; dAddr = 9'h010;
      tick();
      chk_pulses("bad_size_err", 4'b0001);
      chk("bad_size_mfa", ramMFA, 1'b0);
      dReq = 1'b0;
      tick();

      // Misaligned fetch.
      ifReq = 1'b1; ifAddr = 9'h042;
      tick();
      chk_pulses("mis_fetch_err", 4'b0100);
      chk("mis_fetch_owner", owner, 1'b0);
      ifReq = 1'b0;
      tick();

      // Byte read at an odd address is legal.
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b00; dAddr = 9'h013;
      tick();
      chk("byte_mfa", ramMFA, 1'b1);
      chk("byte_size", ramDataSize, 2'b00);
      ramMFC = 1'b1; ramDataIn = 32'h000000A5;
      tick();
      chk_pulses("byte_done", 4'b0010);
      chk("byte_rdata", rdata, 32'h000000A5);
      dReq = 1'b0; ramMFC = 1'b0;
      tick();

      // Data read with MFC never arriving: 15 MFA cycles, then dErr.
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b11; dAddr = 9'h020;
      mfa_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (ramMFA) mfa_cnt++;
         if (i == 3) dReq = 1'b0;
      end
      chk("timeout_mfa_cycles", mfa_cnt, 15);
      chk_pulses("timeout_no_early_err", 4'b0000);
      tick();
      chk_pulses("timeout_err", 4'b0001);
      chk("timeout_mfa_off", ramMFA, 1'b0);
      chk("timeout_rdata", rdata, 32'h000000A5);
      tick();
      chk_pulses("timeout_err_end", 4'b0000);
      ifReq = 1'b1; ifAddr = 9'h044;
      tick();
      chk("after_to_fetch_mfa", ramMFA, 1'b1);
      ramMFC = 1'b1; ramDataIn = 32'hDEADBEEF;
      tick();
      chk_pulses("after_to_fetch_done", 4'b1000);
      chk("after_to_fetch_rdata", rdata, 32'hDEADBEEF);
      ifReq = 1'b0; ramMFC = 1'b0;
      tick();

      // Reset on the 2nd ACCESS cycle of a word write.
      dReq = 1'b1; dRW = 1'b1; dSize = 2'b11; dAddr = 9'h0F0; dWdata = 32'h12345678;
      tick();
      tick();
      chk("rst_mid_mfa_before", ramMFA, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_mfa", ramMFA, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_owner", owner, 1'b1);
      chk_pulses("rst_mid_no_pulse", 4'b0000);
      dReq = 1'b0; ramMFC = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk_pulses("rst_mid_after_no_pulse", 4'b0000);
      chk("rst_mid_after_busy", busy, 1'b0);
      ramMFC = 1'b0;

      // Both requesters held continuously, MFC immediate: strict alternation.
      ifReq = 1'b1; ifAddr = 9'h004;
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b11; dAddr = 9'h008;
      ramMFC = 1'b1; ramDataIn = 32'h0BADCAFE;
      for (int k = 0; k < 4; k++) begin
         logic exp_own;
         exp_own = (k % 2 == 1);
         tick();
         chk($sformatf("rr%0d_owner", k), owner, exp_own);
         chk($sformatf("rr%0d_addr", k), ramAddress, exp_own ? 32'h008 : 32'h004);
         tick();
         chk_pulses($sformatf("rr%0d_done", k), exp_own ? 4'b0010 : 4'b1000);
         tick();
         chk_pulses($sformatf("rr%0d_done_end", k), 4'b0000);
      end
      ifReq = 1'b0; dReq = 1'b0; ramMFC = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
